// File: rtl/mem_responder.sv
// Single-outstanding memory responder in front of a word-addressed on-chip RAM.
// Optional MEM_RESP_BOUNDS_CHECK_EN adds RESP_ERR and rejects out-of-range addresses.
module mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_ADDR_VALID,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_DATA_VALID,
    input  logic [31:0] REQ_DATA,
    output logic        REQ_READY,
    output logic        RESP_VALID,
    output logic [31:0] RESP_DATA,
    input  logic        RESP_READY,
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    output logic        RESP_ERR,
`endif
    output logic [31:0] REQ_COUNT
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t state, state_n;

    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic              wr_q, wr_n;
    logic              first_q, first_n;
    logic              oob_q, oob_n;
    logic              ready_n;
    logic              valid_n;
    logic [31:0]       rdata_n;
    logic [31:0]       count_n;
    logic              mem_we;
    logic              req_oob;
    logic              accept;

    logic [31:0] mem [DEPTH];

`ifdef MEM_RESP_BOUNDS_CHECK_EN
    logic err_n;
    assign req_oob = |REQ_ADDR[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |REQ_ADDR[31:ADDR_W];
    assign req_oob = 1'b0;
`endif

    assign accept = REQ_ADDR_VALID && REQ_READY;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        wr_n    = wr_q;
        first_n = first_q;
        oob_n   = oob_q;
        ready_n = REQ_READY;
        valid_n = RESP_VALID;
        rdata_n = RESP_DATA;
        count_n = REQ_COUNT;
        mem_we  = 1'b0;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
        err_n   = RESP_ERR;
`endif
        unique case (1'b1)
            state == S_IDLE: begin
                ready_n = 1'b1;
                if (accept) begin
                    addr_n  = REQ_ADDR[ADDR_W-1:0];
                    wdata_n = REQ_DATA;
                    wr_n    = REQ_DATA_VALID;
                    oob_n   = req_oob;
                    first_n = 1'b1;
                    count_n = REQ_COUNT + 32'd1;
                    cnt_n   = CNT_INIT;
                    ready_n = 1'b0;
                    state_n = S_ACCESS;
                end
            end
            state == S_ACCESS: begin
                first_n = 1'b0;
                // commit early so a later read of the same word sees it
                mem_we  = first_q && wr_q && !oob_q && RST_N;
                if (cnt == 4'd0) begin
                    if (oob_q) begin
                        rdata_n = ERR_WORD;
                    end else if (wr_q) begin
                        rdata_n = wdata_q;
                    end else begin
                        rdata_n = mem[addr_q];
                    end
`ifdef MEM_RESP_BOUNDS_CHECK_EN
                    err_n   = oob_q;
`endif
                    valid_n = 1'b1;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            state == S_RESP: begin
                if (RESP_READY) begin
                    valid_n = 1'b0;
                    ready_n = 1'b1;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
                    err_n   = 1'b0;
`endif
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wr_q       <= 1'b0;
            first_q    <= 1'b0;
            oob_q      <= 1'b0;
            REQ_READY  <= 1'b0;
            RESP_VALID <= 1'b0;
            RESP_DATA  <= 32'd0;
            REQ_COUNT  <= 32'd0;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
            RESP_ERR   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            wr_q       <= wr_n;
            first_q    <= first_n;
            oob_q      <= oob_n;
            REQ_READY  <= ready_n;
            RESP_VALID <= valid_n;
            RESP_DATA  <= rdata_n;
            REQ_COUNT  <= count_n;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
            RESP_ERR   <= err_n;
`endif
        end
    end

    // RAM is not reset; contents survive RST_N
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: cycle model compared every cycle plus directed literal checks.
// Build with +define+MEM_RESP_BOUNDS_CHECK_EN to cover the bounds-check variant.
module tb_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam logic [31:0] AMASK = 32'h3FF;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_ADDR_VALID = 1'b0;
    logic [31:0] REQ_ADDR = 32'd0;
    logic        REQ_DATA_VALID = 1'b0;
    logic [31:0] REQ_DATA = 32'd0;
    logic        RESP_READY = 1'b1;
    logic        REQ_READY;
    logic        RESP_VALID;
    logic [31:0] RESP_DATA;
    logic [31:0] REQ_COUNT;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    logic        RESP_ERR;
`endif

    mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .REQ_ADDR_VALID(REQ_ADDR_VALID),
        .REQ_ADDR(REQ_ADDR),
        .REQ_DATA_VALID(REQ_DATA_VALID),
        .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY),
        .RESP_VALID(RESP_VALID),
        .RESP_DATA(RESP_DATA),
        .RESP_READY(RESP_READY),
`ifdef MEM_RESP_BOUNDS_CHECK_EN
        .RESP_ERR(RESP_ERR),
`endif
        .REQ_COUNT(REQ_COUNT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: timestamps and an associative memory, no FSM.
    logic [31:0] mmem [int];
    bit          m_ready = 0;
    bit          m_valid = 0;
    bit          m_err = 0;
    logic [31:0] m_data = 0;
    logic [31:0] m_count = 0;
    int          cyc = 0;
    int          commit_at = -1;
    int          resp_at = -1;
    logic [31:0] p_addr = 0;
    logic [31:0] p_data = 0;
    bit          p_wr = 0;
    bit          p_oob = 0;
    bit          o_ready, o_valid;
    bit          force_req = 0;
    int          acc_cyc = 0;
    int          acc_gap = 0;
    int          n_acc = 0;

    function automatic bit is_oob(input logic [31:0] a);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
        return (a >> AW) != 0;
`else
        return a == 32'hFFFF_FFFF && a != 32'hFFFF_FFFF;
`endif
    endfunction

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (RST_N && REQ_READY && REQ_ADDR_VALID) begin
            n_acc   = n_acc + 1;
            acc_gap = cyc - acc_cyc;
            acc_cyc = cyc;
        end
        o_ready = m_ready;
        o_valid = m_valid;
        if (!RST_N) begin
            m_ready = 0;
            m_valid = 0;
            m_err = 0;
            m_data = 0;
            m_count = 0;
            commit_at = -1;
            resp_at = -1;
        end else begin
            if (force_req) m_count = 32'hFFFF_FFFF;
            if (commit_at == cyc) begin
                if (p_wr && !p_oob) mmem[int'(p_addr & AMASK)] = p_data;
                commit_at = -1;
            end
            if (o_ready && REQ_ADDR_VALID) begin
                m_count = m_count + 1;
                m_ready = 0;
                p_addr = REQ_ADDR;
                p_data = REQ_DATA;
                p_wr = REQ_DATA_VALID;
                p_oob = is_oob(REQ_ADDR);
                commit_at = cyc + 1;
                resp_at = cyc + LAT;
            end else if (!o_ready && !o_valid && resp_at < 0) begin
                m_ready = 1;
            end
            if (o_valid && RESP_READY) begin
                m_valid = 0;
                m_ready = 1;
            end
            if (resp_at == cyc) begin
                m_valid = 1;
                m_err = p_oob;
                if (p_oob) m_data = 32'hDEADBEEF;
                else if (p_wr) m_data = p_data;
                else m_data = mmem[int'(p_addr & AMASK)];
                resp_at = -1;
            end
        end
    end

    always @(negedge CLK) begin
        chk("req_ready", {31'd0, REQ_READY}, {31'd0, m_ready});
        chk("resp_valid", {31'd0, RESP_VALID}, {31'd0, m_valid});
        chk("resp_data", RESP_DATA, m_data);
        chk("req_count", REQ_COUNT, m_count);
        chk("one_outstanding", {31'd0, REQ_READY && RESP_VALID}, 32'd0);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
        if (m_valid) chk("resp_err", {31'd0, RESP_ERR}, {31'd0, m_err});
`endif
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input bit wr);
        int i;
        for (i = 0; i < 50; i++) begin
            if (REQ_READY) break;
            tick();
        end
        if (i == 50) begin
            errors++;
            $display("FAIL send_timeout: REQ_READY stayed 0, required 1");
        end
        REQ_ADDR = a;
        REQ_DATA = d;
        REQ_DATA_VALID = wr;
        REQ_ADDR_VALID = 1'b1;
        tick();
        REQ_ADDR_VALID = 1'b0;
        REQ_DATA_VALID = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] d, output int lat, output bit err);
        int i;
        d = 32'd0;
        lat = -1;
        err = 0;
        for (i = 0; i < 50; i++) begin
            if (RESP_VALID) break;
            tick();
        end
        if (i == 50) begin
            errors++;
            $display("FAIL resp_timeout: RESP_VALID stayed 0, required 1");
        end else begin
            d = RESP_DATA;
            lat = cyc - acc_cyc;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
            err = RESP_ERR;
`endif
        end
        tick();
    endtask

    logic [31:0] d;
    int          lat;
    bit          e;
    int          base;

    initial begin
        RST_N = 1'b0;
        repeat (3) tick();
        chk("rst_ready", {31'd0, REQ_READY}, 32'd0);
        chk("rst_valid", {31'd0, RESP_VALID}, 32'd0);
        chk("rst_count", REQ_COUNT, 32'd0);
        RST_N = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, REQ_READY}, 32'd1);

        send(32'd5, 32'hCAFE0001, 1);
        get_resp(d, lat, e);
        chk("wr_data", d, 32'hCAFE0001);
        chk("wr_latency", lat, LAT);
        send(32'd5, 32'h0, 0);
        get_resp(d, lat, e);
        chk("rd_data", d, 32'hCAFE0001);
        chk("rd_latency", lat, LAT);
        chk("count_two", REQ_COUNT, 32'd2);

        RESP_READY = 1'b0;
        send(32'd5, 32'h0, 0);
        repeat (LAT) tick();
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", {31'd0, RESP_VALID}, 32'd1);
            chk("bp_data", RESP_DATA, 32'hCAFE0001);
            chk("bp_ready", {31'd0, REQ_READY}, 32'd0);
            tick();
        end
        RESP_READY = 1'b1;
        tick();
        chk("bp_release_ready", {31'd0, REQ_READY}, 32'd1);
        chk("bp_release_valid", {31'd0, RESP_VALID}, 32'd0);

        send(32'd9, 32'hA5A50009, 1);
        tick();
        RST_N = 1'b0;
        repeat (2) tick();
        chk("midrst_valid", {31'd0, RESP_VALID}, 32'd0);
        chk("midrst_count", REQ_COUNT, 32'd0);
        RST_N = 1'b1;
        tick();
        chk("midrst_ready", {31'd0, REQ_READY}, 32'd1);
        send(32'd9, 32'h0, 0);
        get_resp(d, lat, e);
        chk("midrst_ram9", d, 32'hA5A50009);

`ifdef MEM_RESP_BOUNDS_CHECK_EN
        send(32'h405, 32'h12, 1);
        get_resp(d, lat, e);
        chk("oob_data", d, 32'hDEADBEEF);
        chk("oob_err", {31'd0, e}, 32'd1);
        send(32'd5, 32'h0, 0);
        get_resp(d, lat, e);
        chk("oob_keep5", d, 32'hCAFE0001);
        chk("oob_err0", {31'd0, e}, 32'd0);
`else
        send(32'h405, 32'h12, 1);
        get_resp(d, lat, e);
        chk("alias_wr", d, 32'h12);
        send(32'd5, 32'h0, 0);
        get_resp(d, lat, e);
        chk("alias_rd5", d, 32'h12);
`endif

        base = n_acc;
        REQ_ADDR = 32'd5;
        REQ_DATA_VALID = 1'b0;
        REQ_ADDR_VALID = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (n_acc >= base + 3) break;
            tick();
        end
        REQ_ADDR_VALID = 1'b0;
        chk("b2b_accepts", n_acc - base, 3);
        chk("b2b_gap", acc_gap, LAT + 2);
        get_resp(d, lat, e);

        for (int k = 0; k < 20 && !REQ_READY; k++) tick();
        @(negedge CLK);
        #1;
        force dut.REQ_COUNT = 32'hFFFF_FFFF;
        force_req = 1;
        @(posedge CLK);
        #2;
        force_req = 0;
        release dut.REQ_COUNT;
        chk("wrap_forced", REQ_COUNT, 32'hFFFF_FFFF);
        send(32'd5, 32'h0, 0);
        chk("wrap_zero", REQ_COUNT, 32'd0);
        get_resp(d, lat, e);
        chk("wrap_rd", d, 32'h12 ^ (is_oob(32'h405) ? 32'hCAFE0013 : 32'h0));

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
